axi_read_arbiter: RTL and testbench
===================================

AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 2: number of cache read-channel requesters sharing one AXI read port (2..8).
REQ-002 Parameter ADDR_W, default 32: AXI address width.
REQ-003 Parameter DATA_W, default 32: AXI data width.
REQ-004 Parameter LEN_W, default 8: AXI burst-length width.
REQ-005 Parameter ID_W, default 1: AXI ID width.
REQ-006 ap_clk  in  1  sole clock; all state updates on rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 s_arvalid  in  NUM_REQ  per-requester read-address valid.
REQ-009 s_arready  out  NUM_REQ  per-requester read-address ready.
REQ-010 s_araddr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies slice i.
REQ-011 s_arlen  in  NUM_REQ*LEN_W  flattened burst lengths.
REQ-012 s_arsize/s_arburst  in  NUM_REQ*3 / NUM_REQ*2  flattened size and burst type.
REQ-013 s_rvalid  out  NUM_REQ  per-requester read-data valid.
REQ-014 s_rready  in  NUM_REQ  per-requester read-data ready.
REQ-015 s_rdata/s_rresp/s_rlast  out  DATA_W/2/1  broadcast to all requesters, qualified only by s_rvalid.
REQ-016 m_axi_arvalid/arready/araddr/arlen/arsize/arburst/arid  out/in/out/out/out/out/out  1/1/ADDR_W/LEN_W/3/2/ID_W  master address channel.
REQ-017 m_axi_rvalid/rready/rdata/rresp/rlast  in/out/in/in/in  1/1/DATA_W/2/1  master data channel.
REQ-018 grant_id  out  $clog2(NUM_REQ)  index of the requester owning the port; valid when busy=1.
REQ-019 busy  out  1  high in ADDR and DATA states.

Function
REQ-020 FSM states: IDLE, ADDR, DATA; one outstanding burst at a time.
REQ-021 IDLE: when any s_arvalid=1, register grant = first requesting index at or after rr_ptr (wrapping modulo NUM_REQ) and enter ADDR on the next edge; otherwise remain.
REQ-022 ADDR: m_axi_arvalid = s_arvalid[grant]; m_axi_ar* fields = granted slices; s_arready[grant] = m_axi_arready; all other s_arready = 0; on m_axi_arvalid&m_axi_arready go to DATA.
REQ-023 m_axi_arid = grant_id zero-extended/truncated to ID_W.
REQ-024 DATA: s_rvalid[grant] = m_axi_rvalid; m_axi_rready = s_rready[grant]; other s_rvalid = 0.
REQ-025 DATA: on m_axi_rvalid&m_axi_rready&m_axi_rlast go to IDLE and set rr_ptr = grant+1 modulo NUM_REQ.
REQ-026 The grant does not change mid-burst; an rresp error does not end the burst early (the requester handles retry).
REQ-027 Latency: s_arvalid rising in IDLE at cycle N produces m_axi_arvalid at cycle N+1; back-to-back bursts have exactly one IDLE cycle between rlast and the next m_axi_arvalid.
REQ-028 In IDLE and DATA, m_axi_arvalid=0 and all s_arready=0; in IDLE and ADDR, m_axi_rready=0 and all s_rvalid=0.
REQ-029 Simultaneous requests are served in round-robin order; a continuously requesting requester waits at most NUM_REQ-1 bursts.
REQ-030 If the granted s_arvalid drops in ADDR before the handshake (protocol violation), return to IDLE without advancing rr_ptr.

Reset
REQ-031 Reset forces state=IDLE, grant=0, rr_ptr=0, busy=0; every valid/ready output is 0 while reset is high.
REQ-032 Reset asserted mid-burst abandons the burst immediately; no data is forwarded after reset deassertion.

Structure
REQ-033 State encoding (IDLE=0, ADDR=1, DATA=2) and the AXI burst-type constant INCR=2'b01 live in the shared cache header/package.
REQ-034 The round-robin pick logic is one combinational sub-module, rr_pick (inputs req vector and ptr; outputs index and any_req).

Verification
REQ-035 Single request: s_arvalid[0]=1, addr 0x100, len 3 -> m_axi_arvalid next cycle with araddr 0x100, arlen 3; 4 beats routed to s_rvalid[0] only; busy drops one cycle after rlast.
REQ-036 Simultaneous requests, NUM_REQ=2, both held -> grant order 0,1,0,1 over four bursts.
REQ-037 Backpressure: s_rready[grant] toggling 1,0,1,0 -> m_axi_rready mirrors it; beat count is unchanged; rlast accepted only with handshake.
REQ-038 Error beat: rresp=2'b10 on beat 2 of 4 -> all 4 beats delivered, FSM stays in DATA until rlast.
REQ-039 Reset asserted in DATA after beat 1 -> all outputs 0 the same cycle; after release, a new request from requester 1 is granted with rr_ptr=0.
REQ-040 Wrap-around, NUM_REQ=3, rr_ptr=2, requests on 0 and 2 -> grant 2, then 0.

Source files
------------

// File: rtl/axi_read_arbiter_pkg.sv
// Shared constants for the cache read-port arbiter: FSM encoding, AXI burst type, pointer helper.
package axi_read_arbiter_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ADDR    = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;

    localparam logic [1:0] BURST_INCR = 2'b01;

    // Next round-robin position after idx, wrapping at n.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_read_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N = 2,
    parameter int unsigned W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any_req
);

    int unsigned cand;
    logic        found;

    always_comb begin
        idx     = '0;
        any_req = |req;
        cand    = 0;
        found   = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[W'(cand)]) begin
                idx   = W'(cand);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port among NUM_REQ cache requesters, one outstanding burst at a time,
// granted round-robin and held for the whole burst.
module axi_read_arbiter
    import axi_read_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 8,
    parameter int unsigned ID_W    = 1
) (
    input  logic                          ap_clk,
    input  logic                          reset,

    input  logic [NUM_REQ-1:0]            s_arvalid,
    output logic [NUM_REQ-1:0]            s_arready,
    input  logic [NUM_REQ*ADDR_W-1:0]     s_araddr,
    input  logic [NUM_REQ*LEN_W-1:0]      s_arlen,
    input  logic [NUM_REQ*3-1:0]          s_arsize,
    input  logic [NUM_REQ*2-1:0]          s_arburst,
    output logic [NUM_REQ-1:0]            s_rvalid,
    input  logic [NUM_REQ-1:0]            s_rready,
    output logic [DATA_W-1:0]             s_rdata,
    output logic [1:0]                    s_rresp,
    output logic                          s_rlast,

    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    output logic [ADDR_W-1:0]             m_axi_araddr,
    output logic [LEN_W-1:0]              m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic [ID_W-1:0]               m_axi_arid,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    input  logic [DATA_W-1:0]             m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,

    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [1:0]       state_q,  state_d;
    logic [IDX_W-1:0] grant_q,  grant_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic             busy_q,   busy_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             gnt_arvalid;
    logic             gnt_rready;

    rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_rr_pick (
        .req     (s_arvalid),
        .ptr     (rr_ptr_q),
        .idx     (pick_idx),
        .any_req (pick_any)
    );

    assign gnt_arvalid = s_arvalid[grant_q];
    assign gnt_rready  = s_rready[grant_q];

    // Address fields always follow the granted slice; only arvalid qualifies them.
    assign m_axi_araddr  = s_araddr[32'(grant_q) * ADDR_W +: ADDR_W];
    assign m_axi_arlen   = s_arlen[32'(grant_q) * LEN_W +: LEN_W];
    assign m_axi_arsize  = s_arsize[32'(grant_q) * 3 +: 3];
    assign m_axi_arburst = s_arburst[32'(grant_q) * 2 +: 2];
    assign m_axi_arid    = ID_W'(grant_q);

    assign s_rdata = m_axi_rdata;
    assign s_rresp = m_axi_rresp;
    assign s_rlast = m_axi_rlast;

    assign grant_id = grant_q;
    assign busy     = busy_q;

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        s_arready     = '0;
        s_rvalid      = '0;

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_idx;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                m_axi_arvalid      = gnt_arvalid;
                s_arready[grant_q] = m_axi_arready;
                // A withdrawn request abandons the grant without moving the pointer.
                if (!gnt_arvalid) begin
                    state_d = ST_IDLE;
                end else if (m_axi_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                m_axi_rready      = gnt_rready;
                s_rvalid[grant_q] = m_axi_rvalid;
                if (m_axi_rvalid && gnt_rready && m_axi_rlast) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = IDX_W'(wrap_inc(32'(grant_q), NUM_REQ));
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge ap_clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench for axi_read_arbiter with three requesters and a behavioural AXI read slave.
module tb_axi_read_arbiter;
    import axi_read_arbiter_pkg::*;

    localparam int unsigned NR = 3;

    logic            ap_clk;
    logic            reset;
    logic [NR-1:0]   s_arvalid;
    logic [NR-1:0]   s_arready;
    logic [NR*32-1:0] s_araddr;
    logic [NR*8-1:0] s_arlen;
    logic [NR*3-1:0] s_arsize;
    logic [NR*2-1:0] s_arburst;
    logic [NR-1:0]   s_rvalid;
    logic [NR-1:0]   s_rready;
    logic [31:0]     s_rdata;
    logic [1:0]      s_rresp;
    logic            s_rlast;
    logic            m_axi_arvalid;
    logic            m_axi_arready;
    logic [31:0]     m_axi_araddr;
    logic [7:0]      m_axi_arlen;
    logic [2:0]      m_axi_arsize;
    logic [1:0]      m_axi_arburst;
    logic [0:0]      m_axi_arid;
    logic            m_axi_rvalid;
    logic            m_axi_rready;
    logic [31:0]     m_axi_rdata;
    logic [1:0]      m_axi_rresp;
    logic            m_axi_rlast;
    logic [1:0]      grant_id;
    logic            busy;

    axi_read_arbiter #(
        .NUM_REQ (NR)
    ) dut (
        .ap_clk        (ap_clk),
        .reset         (reset),
        .s_arvalid     (s_arvalid),
        .s_arready     (s_arready),
        .s_araddr      (s_araddr),
        .s_arlen       (s_arlen),
        .s_arsize      (s_arsize),
        .s_arburst     (s_arburst),
        .s_rvalid      (s_rvalid),
        .s_rready      (s_rready),
        .s_rdata       (s_rdata),
        .s_rresp       (s_rresp),
        .s_rlast       (s_rlast),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arid    (m_axi_arid),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .grant_id      (grant_id),
        .busy          (busy)
    );

    typedef struct {
        int          req;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    typedef struct {
        int          req;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_t;

    ar_t  ar_q[$];
    r_t   r_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   rlast_cyc = 0;
    logic rlast_busy = 1'b0;
    int   err_beat = -1;

    initial begin
        ap_clk = 1'b0;
        forever #5 ap_clk = ~ap_clk;
    end

    always @(posedge ap_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge ap_clk);
        #1;
    endtask

    // Expected AR, then every beat; beat data is the slave's addr + 4*beat.
    task automatic exp_burst(input int req, input logic [31:0] addr, input logic [7:0] len, input int eb);
        ar_q.push_back('{req, addr, len});
        for (int b = 0; b <= int'(len); b++) begin
            r_q.push_back('{req, addr + 32'(b * 4), (b == eb) ? 2'b10 : 2'b00, b == int'(len)});
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] addr, input logic [7:0] len);
        s_araddr[i*32 +: 32] = addr;
        s_arlen[i*8 +: 8]    = len;
        s_arsize[i*3 +: 3]   = 3'(i + 1);
        s_arburst[i*2 +: 2]  = BURST_INCR;
        s_arvalid[i]         = 1'b1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ar_q.delete();
        r_q.delete();
        #1;
        chk("reset_outputs", 64'({s_arready, s_rvalid, m_axi_arvalid, m_axi_rready, busy, grant_id}), 64'd0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_ar();
        int b = 0;
        while (ar_q.size() != 0 && b < 200) begin
            at_neg();
            b++;
        end
        chk("ar_wait", 64'(ar_q.size()), 64'd0);
        tick();
    endtask

    task automatic drain();
        int b = 0;
        while ((ar_q.size() != 0 || r_q.size() != 0) && b < 300) begin
            @(posedge ap_clk);
            #2;
            b++;
        end
        chk("drain", 64'(ar_q.size() + r_q.size()), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
    endtask

    // Behavioural AXI slave: one burst at a time, a beat every cycle while active.
    initial begin : slave
        logic        ar_fire, r_fire, r_last, act;
        logic [31:0] cap_addr, b_addr;
        logic [7:0]  cap_len;
        int          b_len, b_beat;
        act = 1'b0; b_addr = '0; b_len = 0; b_beat = 0;
        m_axi_rvalid = 1'b0; m_axi_rdata = '0; m_axi_rresp = '0; m_axi_rlast = 1'b0;
        forever begin
            @(negedge ap_clk);
            ar_fire  = m_axi_arvalid && m_axi_arready;
            cap_addr = m_axi_araddr;
            cap_len  = m_axi_arlen;
            r_fire   = m_axi_rvalid && m_axi_rready;
            r_last   = m_axi_rlast;
            @(posedge ap_clk);
            #1;
            if (reset) begin
                act = 1'b0;
            end else begin
                if (r_fire) begin
                    if (r_last) act = 1'b0;
                    else        b_beat++;
                end
                if (ar_fire) begin
                    act = 1'b1; b_addr = cap_addr; b_len = int'(cap_len); b_beat = 0;
                end
            end
            m_axi_rvalid = act;
            m_axi_rdata  = b_addr + 32'(b_beat * 4);
            m_axi_rresp  = (act && b_beat == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = act && (b_beat == b_len);
        end
    end

    initial begin : mon_ar
        ar_t        e;
        logic [2:0] oh;
        forever begin
            @(negedge ap_clk);
            if (!reset && m_axi_arvalid && m_axi_arready) begin
                chk("ar_expected", 64'(ar_q.size() != 0), 64'd1);
                if (ar_q.size() != 0) begin
                    e  = ar_q.pop_front();
                    oh = 3'b001 << e.req;
                    chk($sformatf("ar_req%0d", e.req),
                        64'({s_arready, grant_id, m_axi_araddr, m_axi_arlen, m_axi_arid, m_axi_arsize, m_axi_arburst}),
                        64'({oh, 2'(e.req), e.addr, e.len, 1'(e.req % 2), 3'(e.req + 1), BURST_INCR}));
                end
            end
        end
    end

    initial begin : mon_r
        r_t         e;
        logic [2:0] oh;
        forever begin
            @(negedge ap_clk);
            if ((s_rvalid & s_rready) != '0) begin
                chk("r_expected", 64'(r_q.size() != 0), 64'd1);
                if (r_q.size() != 0) begin
                    e  = r_q.pop_front();
                    oh = 3'b001 << e.req;
                    chk($sformatf("r_beat_req%0d", e.req),
                        64'({s_rvalid, m_axi_rready, s_rdata, s_rresp, s_rlast}),
                        64'({oh, 1'b1, e.data, e.resp, e.last}));
                    if (e.last) begin
                        rlast_cyc  = cyc;
                        rlast_busy = busy;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d checks failed", n_err, n_vec);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        reset = 1'b1; s_arvalid = '0; s_rready = '1; m_axi_arready = 1'b1;
        s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;

        // Single request: one-cycle AR latency, 4 beats to requester 0, busy falls after rlast.
        do_reset();
        exp_burst(0, 32'h100, 8'd3, -1);
        set_req(0, 32'h100, 8'd3);
        at_neg();
        chk("lat_idle_arvalid", 64'(m_axi_arvalid), 64'd0);
        chk("lat_idle_busy", 64'(busy), 64'd0);
        tick();
        at_neg();
        chk("lat_addr_arvalid", 64'(m_axi_arvalid), 64'd1);
        chk("lat_addr_busy", 64'(busy), 64'd1);
        wait_ar();
        s_arvalid = '0;
        drain();
        chk("busy_fall_delay", 64'(cyc - rlast_cyc), 64'd1);
        chk("busy_at_rlast", 64'(rlast_busy), 64'd1);

        // Two requesters held: grants alternate 0,1,0,1.
        do_reset();
        exp_burst(0, 32'h200, 8'd1, -1);
        exp_burst(1, 32'h300, 8'd1, -1);
        exp_burst(0, 32'h200, 8'd1, -1);
        exp_burst(1, 32'h300, 8'd1, -1);
        set_req(0, 32'h200, 8'd1);
        set_req(1, 32'h300, 8'd1);
        wait_ar();
        s_arvalid = '0;
        drain();

        // Backpressure: rready toggles 1,0,1,0; m_axi_rready follows it until rlast.
        do_reset();
        exp_burst(0, 32'h400, 8'd3, -1);
        set_req(0, 32'h400, 8'd3);
        wait_ar();
        s_arvalid = '0;
        for (int k = 0; k < 8; k++) begin
            s_rready[0] = (k % 2 == 0);
            at_neg();
            chk($sformatf("rready_mirror_%0d", k), 64'(m_axi_rready), 64'((k < 7) && (k % 2 == 0)));
            tick();
        end
        s_rready = '1;
        drain();

        // Error response on the second beat does not end the burst.
        do_reset();
        err_beat = 1;
        exp_burst(1, 32'h500, 8'd3, 1);
        set_req(1, 32'h500, 8'd3);
        wait_ar();
        s_arvalid = '0;
        drain();
        err_beat = -1;

        // Reset mid-burst after one beat; pointer returns to 0 so requester 1 wins over 2.
        do_reset();
        exp_burst(1, 32'h680, 8'd0, -1);
        set_req(1, 32'h680, 8'd0);
        wait_ar();
        s_arvalid = '0;
        drain();
        exp_burst(0, 32'h600, 8'd3, -1);
        set_req(0, 32'h600, 8'd3);
        wait_ar();
        s_arvalid = '0;
        tick();
        do_reset();
        at_neg();
        chk("post_reset_rvalid", 64'(s_rvalid), 64'd0);
        chk("post_reset_busy", 64'(busy), 64'd0);
        tick();
        exp_burst(1, 32'h700, 8'd0, -1);
        exp_burst(2, 32'h780, 8'd0, -1);
        set_req(1, 32'h700, 8'd0);
        set_req(2, 32'h780, 8'd0);
        wait_ar();
        s_arvalid = '0;
        drain();

        // Wrap-around: pointer at 2 with requests on 0 and 2 grants 2 then 0.
        do_reset();
        exp_burst(1, 32'h800, 8'd0, -1);
        set_req(1, 32'h800, 8'd0);
        wait_ar();
        s_arvalid = '0;
        drain();
        exp_burst(2, 32'h900, 8'd1, -1);
        exp_burst(0, 32'hA00, 8'd1, -1);
        set_req(0, 32'hA00, 8'd1);
        set_req(2, 32'h900, 8'd1);
        wait_ar();
        s_arvalid = '0;
        drain();

        // Request withdrawn in ADDR: back to IDLE, pointer unchanged so 0 still wins.
        do_reset();
        m_axi_arready = 1'b0;
        set_req(0, 32'hB00, 8'd0);
        tick();
        at_neg();
        chk("withdraw_arvalid", 64'(m_axi_arvalid), 64'd1);
        chk("withdraw_arready", 64'(s_arready), 64'd0);
        tick();
        s_arvalid = '0;
        at_neg();
        chk("withdraw_drop", 64'(m_axi_arvalid), 64'd0);
        tick();
        at_neg();
        chk("withdraw_idle", 64'(busy), 64'd0);
        tick();
        m_axi_arready = 1'b1;
        exp_burst(0, 32'hC00, 8'd0, -1);
        exp_burst(1, 32'hD00, 8'd0, -1);
        set_req(0, 32'hC00, 8'd0);
        set_req(1, 32'hD00, 8'd0);
        wait_ar();
        s_arvalid = '0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
